branch_predictor: RTL and testbench

- Dynamic branch predictor sitting directly upstream of the IF-stage PC select.
- Consumes the resolved branch outcome from EX and produces a same-cycle taken/target prediction for the PC currently being fetched.
- Direct-mapped branch target buffer (BTB); each entry holds a valid bit, a tag, a 32-bit target and a 2-bit saturating counter.
- Also keeps statistics counters, in the style of the CPU's existing cycle and branch counters.

---
 rtl/branch_predictor.sv | 126 ++++++++++++
 tb/tb_branch_predictor.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch predictor feeding the IF-stage PC select.
//
// A direct-mapped BTB of 2**IDX_BITS entries, each holding a valid bit, a tag,
// a 32-bit target and a 2-bit saturating counter. Lookup is combinational and
// zero-latency. Updates from EX are registered, so they become visible to
// lookups from the following cycle.
//
// Ports:
//   clk, rst        clock; synchronous active-low reset
//   lookup_en       IF stage advancing this cycle (gates hit_cnt only)
//   lookup_pc       PC being fetched
//   pred_taken      prediction for lookup_pc (combinational)
//   pred_target     predicted target, 0 on a BTB miss (combinational)
//   upd_en          a conditional branch resolved in EX this cycle
//   upd_pc          address of the resolved branch
//   upd_taken       actual outcome
//   upd_target      actual taken target
//   upd_mispredict  prediction for that branch was wrong (qualified by upd_en)
//   flush_all       invalidate every BTB entry
//   hit_cnt         cycles with lookup_en & pred_taken (wraps)
//   mispred_cnt     cycles with upd_en & upd_mispredict (wraps)

module branch_predictor #(
  parameter int unsigned IDX_BITS = 3,
  parameter int unsigned PC_BITS  = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_en,
  input  logic [31:0] lookup_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        flush_all,
  output logic [31:0] hit_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned TagBits = PC_BITS - 2 - IDX_BITS;

  logic                valid_q  [Entries];
  logic [TagBits-1:0]  tag_q    [Entries];
  logic [31:0]         target_q [Entries];
  logic [1:0]          ctr_q    [Entries];
  logic [31:0]         hit_cnt_q;
  logic [31:0]         mispred_cnt_q;

  logic [IDX_BITS-1:0] lk_idx;
  logic [TagBits-1:0]  lk_tag;
  logic                lk_hit;
  logic [IDX_BITS-1:0] up_idx;
  logic [TagBits-1:0]  up_tag;
  logic                up_hit;
  logic [1:0]          up_ctr;
  logic [1:0]          ctr_inc;
  logic [1:0]          ctr_dec;

  // Lookup: reads the current (pre-update) contents, no bypass from upd_*.
  always_comb begin
    lk_idx      = lookup_pc[IDX_BITS+1:2];
    lk_tag      = lookup_pc[PC_BITS-1:IDX_BITS+2];
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = lk_hit && ctr_q[lk_idx][1];
    pred_target = lk_hit ? target_q[lk_idx] : 32'h0;
  end

  always_comb begin
    up_idx  = upd_pc[IDX_BITS+1:2];
    up_tag  = upd_pc[PC_BITS-1:IDX_BITS+2];
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr  = ctr_q[up_idx];
    ctr_inc = (up_ctr == 2'b11) ? 2'b11 : up_ctr + 2'b01;
    ctr_dec = (up_ctr == 2'b00) ? 2'b00 : up_ctr - 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 32'h0;
        ctr_q[i]    <= 2'b01;
      end
      hit_cnt_q     <= 32'h0;
      mispred_cnt_q <= 32'h0;
    end else begin
      // Flush only clears valid bits; counters and targets are kept.
      if (flush_all) begin
        for (int i = 0; i < Entries; i++) begin
          valid_q[i] <= 1'b0;
        end
      end else if (upd_en) begin
        if (up_hit) begin
          if (upd_taken) begin
            ctr_q[up_idx]    <= ctr_inc;
            target_q[up_idx] <= upd_target;
          end else begin
            ctr_q[up_idx]    <= ctr_dec;
          end
        end else if (upd_taken) begin
          // Allocate weakly-taken so the very next lookup predicts taken.
          valid_q[up_idx]  <= 1'b1;
          tag_q[up_idx]    <= up_tag;
          target_q[up_idx] <= upd_target;
          ctr_q[up_idx]    <= 2'b10;
        end
      end

      if (lookup_en && pred_taken) begin
        hit_cnt_q <= hit_cnt_q + 32'd1;
      end
      if (upd_en && upd_mispredict) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt     = hit_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed testbench for branch_predictor with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well away from the next edge.

module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        flush_all;
  logic [31:0] hit_cnt;
  logic [31:0] mispred_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .IDX_BITS(3),
    .PC_BITS (12)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .lookup_en     (lookup_en),
    .lookup_pc     (lookup_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .upd_en        (upd_en),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_target    (upd_target),
    .upd_mispredict(upd_mispredict),
    .flush_all     (flush_all),
    .hit_cnt       (hit_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    lookup_en      = 1'b0;
    upd_en         = 1'b0;
    upd_pc         = 32'h0;
    upd_taken      = 1'b0;
    upd_target     = 32'h0;
    upd_mispredict = 1'b0;
    flush_all      = 1'b0;
  endtask

  // One registered update, inputs returned to idle afterwards.
  task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    upd_en     = 1'b1;
    upd_pc     = pc;
    upd_taken  = taken;
    upd_target = tgt;
    tick();
    upd_en     = 1'b0;
    upd_taken  = 1'b0;
  endtask

  task automatic probe(input string tag, input logic [31:0] pc, input logic exp_taken,
                       input logic [31:0] exp_tgt);
    lookup_pc = pc;
    #1;
    check({tag, ".taken"}, {31'h0, pred_taken}, {31'h0, exp_taken});
    check({tag, ".target"}, pred_target, exp_tgt);
  endtask

  initial begin
    idle();
    lookup_pc = 32'h0;
    rst       = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // 1: reset state, lookup misses, hit_cnt stays 0
    check("rst.hit_cnt", hit_cnt, 32'h0);
    check("rst.mispred_cnt", mispred_cnt, 32'h0);
    lookup_en = 1'b1;
    probe("rst.lk10", 32'h10, 1'b0, 32'h0);
    tick();
    check("rst.hit_cnt_after", hit_cnt, 32'h0);
    lookup_en = 1'b0;

    // 2: allocate 0x10 -> 0x40; alias 0x30 shares index 4 with a different tag
    update(32'h10, 1'b1, 32'h40);
    lookup_en = 1'b1;
    probe("alloc.lk10", 32'h10, 1'b1, 32'h40);
    tick();
    check("alloc.hit_cnt", hit_cnt, 32'h1);
    probe("alias.lk30", 32'h30, 1'b0, 32'h0);
    tick();
    check("alias.hit_cnt", hit_cnt, 32'h1);
    lookup_en = 1'b0;

    // 3: counter walk from 10; includes saturation at both ends
    update(32'h10, 1'b0, 32'h0);
    probe("ctr.nt1", 32'h10, 1'b0, 32'h40);     // 01, target unchanged
    update(32'h10, 1'b0, 32'h0);
    probe("ctr.nt2", 32'h10, 1'b0, 32'h40);     // 00
    update(32'h10, 1'b0, 32'h0);
    probe("ctr.nt3", 32'h10, 1'b0, 32'h40);     // stays 00
    update(32'h10, 1'b1, 32'h44);
    probe("ctr.t1", 32'h10, 1'b0, 32'h44);      // 01, target refreshed
    update(32'h10, 1'b1, 32'h44);
    probe("ctr.t2", 32'h10, 1'b1, 32'h44);      // 10
    update(32'h10, 1'b1, 32'h44);
    probe("ctr.t3", 32'h10, 1'b1, 32'h44);      // 11
    update(32'h10, 1'b1, 32'h48);
    probe("ctr.t4", 32'h10, 1'b1, 32'h48);      // stays 11
    update(32'h10, 1'b0, 32'h0);
    probe("ctr.sat_nt1", 32'h10, 1'b1, 32'h48); // 10
    update(32'h10, 1'b0, 32'h0);
    probe("ctr.sat_nt2", 32'h10, 1'b0, 32'h48); // 01

    // 4: same-cycle lookup and allocate on 0x14 -> no bypass
    lookup_en  = 1'b1;
    upd_en     = 1'b1;
    upd_pc     = 32'h14;
    upd_taken  = 1'b1;
    upd_target = 32'h80;
    probe("same.before", 32'h14, 1'b0, 32'h0);
    tick();
    upd_en    = 1'b0;
    upd_taken = 1'b0;
    probe("same.after", 32'h14, 1'b1, 32'h80);
    tick();
    check("same.hit_cnt", hit_cnt, 32'h2);
    lookup_en = 1'b0;
    probe("ignored_bits", 32'hF000_0017, 1'b1, 32'h80);

    // 5: mispredict counting, qualification by upd_en, then flush
    upd_pc         = 32'h100;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b1;
    upd_en         = 1'b1;
    tick();
    tick();
    tick();
    upd_en = 1'b0;
    tick();
    tick();
    check("mispred.cnt", mispred_cnt, 32'h3);
    upd_mispredict = 1'b0;
    // flush with a would-be allocating update: flush wins
    flush_all  = 1'b1;
    upd_en     = 1'b1;
    upd_pc     = 32'h18;
    upd_taken  = 1'b1;
    upd_target = 32'h99;
    tick();
    idle();
    probe("flush.lk10", 32'h10, 1'b0, 32'h0);
    probe("flush.lk14", 32'h14, 1'b0, 32'h0);
    probe("flush.lk18", 32'h18, 1'b0, 32'h0);
    check("flush.mispred_cnt", mispred_cnt, 32'h3);
    check("flush.hit_cnt", hit_cnt, 32'h2);

    // 6: mid-stream reset beats flush, update and counter increments
    update(32'h10, 1'b1, 32'h40);
    lookup_en = 1'b1;
    probe("pre_rst.lk10", 32'h10, 1'b1, 32'h40);
    tick();
    check("pre_rst.hit_cnt", hit_cnt, 32'h3);
    rst            = 1'b0;
    flush_all      = 1'b1;
    upd_en         = 1'b1;
    upd_pc         = 32'h1C;
    upd_taken      = 1'b1;
    upd_target     = 32'h55;
    upd_mispredict = 1'b1;
    tick();
    rst = 1'b1;
    idle();
    check("rst2.hit_cnt", hit_cnt, 32'h0);
    check("rst2.mispred_cnt", mispred_cnt, 32'h0);
    probe("rst2.lk10", 32'h10, 1'b0, 32'h0);
    probe("rst2.lk1c", 32'h1C, 1'b0, 32'h0);
    // after reset the counter is 01, so a fresh allocate still lands on 10
    update(32'h1C, 1'b1, 32'h60);
    probe("rst2.realloc", 32'h1C, 1'b1, 32'h60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
